// File: rtl/div_unit_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Holds the FSM state encodings and the EX-stage opcodes that request a division.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // The controller decodes these to produce start and signed_div.
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage controller and the divider.
// start is taken only while the divider is IDLE and annul is low; busy rises
// combinationally in that same cycle. ready is a one-cycle pulse qualifying result.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic               annul;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               busy;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Result {remainder, quotient} is registered on leaving END with a one-cycle ready pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       dif,
  output div_state_e state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               sign_q_q;
  logic               sign_r_q;
  logic               ready_q;
  logic [2*WIDTH-1:0] result_q;

  logic load, step, clear, finish;

  // Operand magnitudes; 0x80000000 wraps to itself, which yields the MIPS overflow result.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign a_neg = dif.signed_div & dif.opdata1[WIDTH-1];
  assign b_neg = dif.signed_div & dif.opdata2[WIDTH-1];
  assign abs_a = a_neg ? (~dif.opdata1 + WIDTH'(1)) : dif.opdata1;
  assign abs_b = b_neg ? (~dif.opdata2 + WIDTH'(1)) : dif.opdata2;

  // Shift the next dividend bit (quotient MSB) into the partial remainder and trial-subtract.
  // Bit WIDTH of the difference is set exactly when the subtraction underflowed.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign quo_fix = sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
  assign rem_fix = sign_r_q ? (~rem_q + WIDTH'(1)) : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    clear    = 1'b0;
    finish   = 1'b0;
    dif.busy = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (dif.start && !dif.annul) begin
          load     = 1'b1;
          dif.busy = 1'b1;
          state_d  = (dif.opdata2 == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        dif.busy = 1'b1;
        if (dif.annul) begin
          state_d = DIV_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_END;
        end
      end
      DIV_BYZERO: begin
        dif.busy = 1'b1;
        if (dif.annul) begin
          state_d = DIV_IDLE;
        end else begin
          clear   = 1'b1;
          state_d = DIV_END;
        end
      end
      DIV_END: begin
        finish  = !dif.annul;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= abs_a;
      dvs_q    <= abs_b;
      sign_q_q <= a_neg ^ b_neg;
      sign_r_q <= a_neg;
    end else if (step) begin
      cnt_q <= cnt_q + CW'(1);
      rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else if (clear) begin
      rem_q <= '0;
      quo_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= finish;
      if (finish) result_q <= {rem_fix, quo_fix};
    end
  end

  assign dif.ready  = ready_q;
  assign dif.result = result_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver tasks issue divisions and push the expected
// {remainder, quotient} into a queue; a monitor pops and compares on every ready pulse.
module tb_div_unit;
  import div_unit_pkg::*;

  logic       clk;
  logic       rst;
  div_state_e state_dbg;

  div_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .dif       (dif),
    .state_dbg (state_dbg)
  );

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic prev_ready = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && dif.ready === 1'b1) begin
      logic [63:0] exp;
      n_checks++;
      if (prev_ready) begin
        n_errors++;
        $display("FAIL ready_pulse_width: ready high on consecutive cycles, expected one-cycle pulse");
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ready: got result %h expected no ready pulse", dif.result);
      end else begin
        exp = exp_q.pop_front();
        if (dif.result !== exp) begin
          n_errors++;
          $display("FAIL result: got %h expected %h", dif.result, exp);
        end
      end
    end
    prev_ready = (rst === 1'b1) ? dif.ready : 1'b0;
  end

  // driver: issue one division, measure edges-to-ready and busy cycles
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat, input int exp_busy,
                         input string name);
    int edges;
    int busy_cnt;
    bit seen;
    @(posedge clk);
    #1;
    dif.start      = 1'b1;
    dif.signed_div = s;
    dif.opdata1    = a;
    dif.opdata2    = b;
    exp_q.push_back(exp);
    busy_cnt = 0;
    edges    = 0;
    seen     = 1'b0;
    @(negedge clk);
    if (dif.busy) busy_cnt++;
    @(posedge clk);
    #1 dif.start = 1'b0;
    @(negedge clk);
    if (dif.busy) busy_cnt++;
    while (!seen && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (dif.ready) seen = 1'b1;
      else if (dif.busy) busy_cnt++;
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no ready within 100 cycles, expected ready after %0d", name, exp_lat);
    end else begin
      check64({name, "_latency"}, 64'(edges), 64'(exp_lat));
      check64({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    end
  endtask

  initial begin
    dif.start      = 1'b0;
    dif.signed_div = 1'b0;
    dif.annul      = 1'b0;
    dif.opdata1    = '0;
    dif.opdata2    = '0;
    rst            = 1'b0;
    #12;
    check64("reset_ready", 64'(dif.ready), 64'd0);
    check64("reset_result", dif.result, 64'd0);
    check64("reset_busy", 64'(dif.busy), 64'd0);
    check64("reset_state", 64'(state_dbg), 64'(DIV_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // 1: unsigned normal case, then result must hold
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, "divu_100_7");
    repeat (3) @(negedge clk);
    check64("result_hold", dif.result, {32'd2, 32'd14});
    check64("ready_low_after", 64'(dif.ready), 64'd0);

    // 4: divide by zero
    run_div(1'b0, 32'd5, 32'd0, 64'h0, 2, 2, "divu_5_0");

    // 2/3: signed and boundary cases
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 33, "div_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 33, "div_7_m2");
    run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 33, 33, "div_m100_m7");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 33, "div_overflow");
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 33, "divu_max_1");

    // 5: annul on the 10th ON cycle
    @(posedge clk);
    #1;
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 dif.annul = 1'b1;
    @(posedge clk);
    #1 dif.annul = 1'b0;
    check64("annul_state", 64'(state_dbg), 64'(DIV_IDLE));
    check64("annul_busy", 64'(dif.busy), 64'd0);
    repeat (40) @(negedge clk);
    check64("annul_result_unchanged", dif.result, {32'h0, 32'hFFFF_FFFF});
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 33, "divu_9_3");

    // 6: async reset mid-ON
    @(posedge clk);
    #1;
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.opdata1 = 32'd77; dif.opdata2 = 32'd5;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check64("async_rst_ready", 64'(dif.ready), 64'd0);
    check64("async_rst_result", dif.result, 64'd0);
    check64("async_rst_state", 64'(state_dbg), 64'(DIV_IDLE));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // start held high during busy must be ignored
    fork
      run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 33, "held_start");
      begin
        @(posedge clk);
        @(posedge clk);
        #2;
        dif.start = 1'b1; dif.opdata1 = 32'd50; dif.opdata2 = 32'd5;
        repeat (10) @(posedge clk);
        #2 dif.start = 1'b0;
      end
    join

    // back-to-back divisions
    run_div(1'b1, 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 33, 33, "b2b_div_m9_4");
    run_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 33, "b2b_divu_1000_3");

    repeat (3) @(negedge clk);
    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
